// File: rtl/bsw_stripe_ctrl.sv
// Source/sink controller for the BSW PE systolic chain: feeds reference bases and the
// previous stripe's boundary row into PE0, buffers the last PE's row, and runs the max sweep.
module bsw_stripe_ctrl #(
    parameter int WIDTH           = 10,
    parameter int REF_LEN_WIDTH   = 10,
    parameter int QUERY_LEN_WIDTH = 10,
    parameter int LOG_NUM_PE      = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [REF_LEN_WIDTH-1:0]              ref_length,
    input  logic [REF_LEN_WIDTH-1:0]              ref_start,
    input  logic [QUERY_LEN_WIDTH-1:0]            num_stripes,
    input  logic                                  pad_last,
    input  logic                                  ref_valid,
    output logic                                  ref_ready,
    input  logic [2:0]                            ref_base,
    output logic                                  set_param,
    output logic                                  last_query_sent,
    output logic [REF_LEN_WIDTH-1:0]              start_pos,
    output logic                                  init_out,
    output logic [2:0]                            T_out,
    output logic [WIDTH-1:0]                      V_out,
    output logic [WIDTH-1:0]                      M_out,
    output logic [WIDTH-1:0]                      F_out,
    output logic                                  compute_max_out,
    input  logic                                  init_in,
    input  logic [WIDTH-1:0]                      V_in,
    input  logic [WIDTH-1:0]                      M_in,
    input  logic [WIDTH-1:0]                      F_in,
    input  logic                                  compute_max_in,
    input  logic [REF_LEN_WIDTH-1:0]              max_ref_pos_in,
    input  logic [LOG_NUM_PE-1:0]                 max_query_pos_in,
    input  logic [QUERY_LEN_WIDTH-1:0]            max_stripe_in,
    output logic                                  busy,
    output logic                                  done,
    output logic [WIDTH-1:0]                      result_score,
    output logic [REF_LEN_WIDTH-1:0]              result_ref_pos,
    output logic [QUERY_LEN_WIDTH+LOG_NUM_PE-1:0] result_query_pos,
    output logic [2:0]                            dbg_state
);

    localparam int DEPTH = 1 << REF_LEN_WIDTH;
    localparam logic [WIDTH-1:0] NEG_INF = {2'b11, {(WIDTH-2){1'b0}}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        STREAM   = 3'd2,
        DRAIN    = 3'd3,
        MAX      = 3'd4,
        WAIT_MAX = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t                      state;
    logic [REF_LEN_WIDTH-1:0]    len_q;
    logic [QUERY_LEN_WIDTH-1:0]  stripes_q;
    logic                        pad_q;
    logic [QUERY_LEN_WIDTH-1:0]  stripe;
    logic [QUERY_LEN_WIDTH-1:0]  next_stripe;
    logic [REF_LEN_WIDTH-1:0]    issue_cnt;
    logic [REF_LEN_WIDTH-1:0]    wr_cnt;
    logic [3*WIDTH-1:0]          bnd_mem [DEPTH];
    logic                        xfer;
    logic                        wr_en;

    // ref_valid/ref_ready: a base moves on a rising edge where both are high; ready never
    // depends on valid, and valid may be raised or dropped freely by the source.
    assign ref_ready   = (state == STREAM) && (issue_cnt < len_q);
    assign xfer        = ref_valid && ref_ready;
    assign wr_en       = init_in && (wr_cnt < len_q);
    assign next_stripe = stripe + 1'b1;
    assign dbg_state   = state;

    // Boundary buffer has no reset; stripe 0 never reads it.
    always_ff @(posedge clk) begin
        if (wr_en) bnd_mem[wr_cnt] <= {V_in, M_in, F_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            len_q            <= '0;
            stripes_q        <= '0;
            pad_q            <= 1'b0;
            stripe           <= '0;
            issue_cnt        <= '0;
            wr_cnt           <= '0;
            set_param        <= 1'b0;
            last_query_sent  <= 1'b0;
            start_pos        <= '0;
            init_out         <= 1'b0;
            T_out            <= '0;
            V_out            <= '0;
            M_out            <= '0;
            F_out            <= '0;
            compute_max_out  <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            result_score     <= '0;
            result_ref_pos   <= '0;
            result_query_pos <= '0;
        end else begin
            set_param       <= 1'b0;
            compute_max_out <= 1'b0;
            done            <= 1'b0;
            init_out        <= 1'b0;
            if (wr_en) wr_cnt <= wr_cnt + 1'b1;

            case (state)
                IDLE: if (start) begin
                    len_q            <= ref_length;
                    stripes_q        <= num_stripes;
                    pad_q            <= pad_last;
                    start_pos        <= ref_start;
                    stripe           <= '0;
                    result_score     <= '0;
                    result_ref_pos   <= '0;
                    result_query_pos <= '0;
                    if (ref_length == '0 || num_stripes == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state           <= SETUP;
                        busy            <= 1'b1;
                        set_param       <= 1'b1;
                        last_query_sent <= pad_last && (num_stripes == QUERY_LEN_WIDTH'(1));
                    end
                end
                SETUP: begin
                    last_query_sent <= 1'b0;
                    issue_cnt       <= '0;
                    wr_cnt          <= '0;
                    state           <= STREAM;
                end
                STREAM: if (xfer) begin
                    init_out  <= 1'b1;
                    T_out     <= ref_base;
                    issue_cnt <= issue_cnt + 1'b1;
                    if (stripe == '0) begin
                        V_out <= '0;
                        M_out <= '0;
                        F_out <= NEG_INF;
                    end else begin
                        {V_out, M_out, F_out} <= bnd_mem[issue_cnt];
                    end
                    if (issue_cnt == len_q - 1'b1) state <= DRAIN;
                end
                DRAIN: if (wr_cnt == len_q) begin
                    if (stripe != stripes_q - 1'b1) begin
                        stripe          <= next_stripe;
                        state           <= SETUP;
                        set_param       <= 1'b1;
                        last_query_sent <= pad_q && (next_stripe == stripes_q - 1'b1);
                    end else begin
                        state           <= MAX;
                        compute_max_out <= 1'b1;
                        V_out           <= '0;
                    end
                end
                MAX: state <= WAIT_MAX;
                WAIT_MAX: if (compute_max_in) begin
                    result_score     <= V_in;
                    result_ref_pos   <= max_ref_pos_in;
                    result_query_pos <= {max_stripe_in, max_query_pos_in};
                    state            <= DONE;
                    done             <= 1'b1;
                    busy             <= 1'b0;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bsw_stripe_ctrl.sv
// Bench for bsw_stripe_ctrl: emulates a 4-deep PE chain that returns a known row per stripe,
// and checks every streamed row, the control pulses and the captured max result.
`timescale 1ns/1ps
module tb_bsw_stripe_ctrl;

    localparam int W  = 10;
    localparam int RW = 10;
    localparam int QW = 10;
    localparam int LP = 2;
    localparam logic [W-1:0] NEG_INF = 10'h300;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [RW-1:0]   ref_length = '0;
    logic [RW-1:0]   ref_start = '0;
    logic [QW-1:0]   num_stripes = '0;
    logic            pad_last = 1'b0;
    logic            ref_valid = 1'b0;
    logic            ref_ready;
    logic [2:0]      ref_base = '0;
    logic            set_param, last_query_sent, init_out, compute_max_out;
    logic [RW-1:0]   start_pos;
    logic [2:0]      T_out;
    logic [W-1:0]    V_out, M_out, F_out;
    logic            init_in = 1'b0;
    logic [W-1:0]    V_in = '0, M_in = '0, F_in = '0;
    logic            compute_max_in = 1'b0;
    logic [RW-1:0]   max_ref_pos_in = '0;
    logic [LP-1:0]   max_query_pos_in = '0;
    logic [QW-1:0]   max_stripe_in = '0;
    logic            busy, done;
    logic [W-1:0]    result_score;
    logic [RW-1:0]   result_ref_pos;
    logic [QW+LP-1:0] result_query_pos;
    logic [2:0]      dbg_state;

    bsw_stripe_ctrl #(.WIDTH(W), .REF_LEN_WIDTH(RW), .QUERY_LEN_WIDTH(QW), .LOG_NUM_PE(LP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ref_length(ref_length), .ref_start(ref_start),
        .num_stripes(num_stripes), .pad_last(pad_last), .ref_valid(ref_valid), .ref_ready(ref_ready),
        .ref_base(ref_base), .set_param(set_param), .last_query_sent(last_query_sent),
        .start_pos(start_pos), .init_out(init_out), .T_out(T_out), .V_out(V_out), .M_out(M_out),
        .F_out(F_out), .compute_max_out(compute_max_out), .init_in(init_in), .V_in(V_in),
        .M_in(M_in), .F_in(F_in), .compute_max_in(compute_max_in), .max_ref_pos_in(max_ref_pos_in),
        .max_query_pos_in(max_query_pos_in), .max_stripe_in(max_stripe_in), .busy(busy), .done(done),
        .result_score(result_score), .result_ref_pos(result_ref_pos),
        .result_query_pos(result_query_pos), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // job model state
    int            cur_len = 0, cur_stripes = 0;
    logic          cur_pad = 1'b0;
    logic [RW-1:0] cur_rstart = '0;
    logic [W-1:0]  mx_score = '0;
    logic [RW-1:0] mx_ref = '0;
    logic [QW-1:0] mx_stripe = '0;
    logic [LP-1:0] mx_q = '0;
    int            xfer_total = 0, ret_total = 0, sp_cnt = 0, cm_cnt = 0, done_cnt = 0;
    logic          xfer_prev = 1'b0, done_prev = 1'b0;
    logic [3+3*W-1:0] exp_q[$];

    function automatic logic [W-1:0] ret_v(input int s, input int j);
        return W'(s * 32 + j + 1);
    endfunction
    function automatic logic [W-1:0] ret_m(input int s, input int j);
        return W'(200 + s * 8 + j);
    endfunction
    function automatic logic [W-1:0] ret_f(input int s, input int j);
        return W'(-(s * 4 + j + 3));
    endfunction

    // PE chain stand-in: 4-cycle return path for rows and for the max sweep
    logic [3:0] ipipe = '0, cpipe = '0;
    always @(negedge clk) begin
        int cs, cj;
        if (!rst_n) begin
            ipipe = '0; cpipe = '0; init_in = 1'b0; compute_max_in = 1'b0;
        end else begin
            ipipe = {ipipe[2:0], init_out};
            cpipe = {cpipe[2:0], compute_max_out};
            init_in = ipipe[3];
            compute_max_in = cpipe[3];
            if (ipipe[3]) begin
                cs = ret_total / cur_len; cj = ret_total % cur_len;
                V_in = ret_v(cs, cj); M_in = ret_m(cs, cj); F_in = ret_f(cs, cj);
                ret_total++;
            end else if (cpipe[3]) begin
                V_in = mx_score; max_ref_pos_in = mx_ref;
                max_stripe_in = mx_stripe; max_query_pos_in = mx_q;
            end
        end
    end

    // scoreboard / monitor
    always @(negedge clk) begin
        int ms, mj;
        logic [3+3*W-1:0] e;
        if (!rst_n) begin
            xfer_prev = 1'b0; done_prev = 1'b0;
        end else begin
            check("init_lat", init_out, xfer_prev);
            if (init_out) begin
                check("sb_avail", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("row", {T_out, V_out, M_out, F_out}, e);
                end
            end
            if (set_param) begin
                check("sp_order", ret_total, sp_cnt * cur_len);
                check("last_q", last_query_sent, cur_pad && (sp_cnt == cur_stripes - 1));
                check("start_pos", start_pos, cur_rstart);
                sp_cnt++;
            end
            if (compute_max_out) begin
                check("cm_v", V_out, '0);
                check("cm_drain", ret_total, cur_len * cur_stripes);
                cm_cnt++;
            end
            if (done) begin
                check("done_1cyc", done_prev, 1'b0);
                check("busy_at_done", busy, 1'b0);
                done_cnt++;
            end
            done_prev = done;
            xfer_prev = ref_valid && ref_ready;
            if (xfer_prev) begin
                ms = xfer_total / cur_len; mj = xfer_total % cur_len;
                if (ms == 0) exp_q.push_back({ref_base, W'(0), W'(0), NEG_INF});
                else exp_q.push_back({ref_base, ret_v(ms - 1, mj), ret_m(ms - 1, mj), ret_f(ms - 1, mj)});
                xfer_total++;
            end
        end
    end

    // driver: vmode 0 = valid always, 1 = 1010..., 2 = random; poke pulses start mid-job
    task automatic run_job(input int len, input int stripes, input bit pad, input int rstart,
                           input int vmode, input logic [W-1:0] ms, input int mref,
                           input int mstr, input int mq, input bit poke);
        bit zero;
        bit timeout;
        cur_len = len; cur_stripes = stripes; cur_pad = pad; cur_rstart = RW'(rstart);
        mx_score = ms; mx_ref = RW'(mref); mx_stripe = QW'(mstr); mx_q = LP'(mq);
        xfer_total = 0; ret_total = 0; sp_cnt = 0; cm_cnt = 0; done_cnt = 0;
        exp_q.delete();
        zero = (len == 0) || (stripes == 0);
        @(posedge clk); #1;
        start = 1'b1; ref_length = RW'(len); ref_start = RW'(rstart);
        num_stripes = QW'(stripes); pad_last = pad;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        if (zero) check("zero_done", done, 1'b1);
        else check("busy_on_start", busy, 1'b1);
        timeout = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (done_cnt > 0) begin
                timeout = 1'b0;
                break;
            end
            ref_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            ref_base  = 3'($urandom_range(0, 4));
            if (poke && c == 6) begin
                start = 1'b1; num_stripes = QW'(7); ref_length = RW'(3);
            end else begin
                start = 1'b0; num_stripes = QW'(stripes); ref_length = RW'(len);
            end
        end
        ref_valid = 1'b0;
        start = 1'b0;
        check("job_timeout", timeout, 1'b0);
        check("res_score", result_score, zero ? '0 : ms);
        check("res_ref_pos", result_ref_pos, zero ? '0 : RW'(mref));
        check("res_query_pos", result_query_pos, zero ? '0 : {QW'(mstr), LP'(mq)});
        check("sp_count", sp_cnt, zero ? 0 : stripes);
        check("cm_count", cm_cnt, zero ? 0 : 1);
        check("xfer_count", xfer_total, len * stripes);
        check("sb_drained", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("done_once", done_cnt, 1);
        check("busy_idle", busy, 1'b0);
    endtask

    task automatic reset_mid_job();
        bit seen;
        cur_len = 6; cur_stripes = 2; cur_pad = 1'b0; cur_rstart = RW'(11);
        xfer_total = 0; ret_total = 0; sp_cnt = 0; cm_cnt = 0; done_cnt = 0;
        exp_q.delete();
        @(posedge clk); #1;
        start = 1'b1; ref_length = RW'(6); ref_start = RW'(11); num_stripes = QW'(2);
        pad_last = 1'b0; ref_valid = 1'b1; ref_base = 3'd2;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (init_out) seen = 1'b1;
        end
        check("rst_reach_stream", seen, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_ctl", {set_param, last_query_sent, init_out, compute_max_out, busy, done,
                                ref_ready, dbg_state, T_out, start_pos}, '0);
        check("rst_async_data", {V_out, M_out, F_out, result_score, result_ref_pos, result_query_pos}, '0);
        ref_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ctl", {set_param, last_query_sent, init_out, compute_max_out, busy, done,
                            ref_ready, dbg_state, T_out, start_pos}, '0);
        check("reset_data", {V_out, M_out, F_out, result_score, result_ref_pos, result_query_pos}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_job(8, 1, 1'b0, 3, 0, 10'd55, 20, 0, 3, 1'b0);   // basic single stripe
        run_job(5, 2, 1'b1, 0, 0, 10'd37, 12, 1, 2, 1'b0);   // two stripes, max capture
        run_job(8, 3, 1'b0, 17, 1, 10'h3FB, 7, 2, 1, 1'b1);  // backpressure, negative score
        run_job(8, 0, 1'b0, 5, 0, 10'd99, 1, 1, 1, 1'b0);    // zero stripes
        run_job(1, 2, 1'b1, 9, 2, 10'd100, 0, 1, 0, 1'b0);   // single-base stripes
        run_job(0, 2, 1'b0, 0, 0, 10'd44, 3, 0, 1, 1'b0);    // zero length
        reset_mid_job();
        run_job(6, 2, 1'b0, 4, 2, 10'd77, 5, 1, 1, 1'b0);    // clean job after abort

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
